// File: rtl/dhcp_vlg_core.sv
// DHCP client control core: sequences DISCOVER/REQUEST, filters replies by type and
// transaction ID, retries on timeout or NAK, and reports BOUND/FAIL.
module dhcp_vlg_core #(
    parameter int unsigned TIMEOUT  = 1250000,
    parameter int unsigned RETRIES  = 3,
    parameter logic [31:0] XID_INIT = 32'hdeadbeef
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        tx_val,
    output logic [7:0]  tx_msg_type,
    output logic [31:0] tx_xid,
    output logic [31:0] tx_req_ip,
    output logic [31:0] tx_src_ip,
    output logic [31:0] tx_dst_ip,
    output logic [15:0] tx_ipv4_id,
    input  logic        tx_done,
    input  logic        rx_val,
    input  logic [7:0]  rx_msg_type,
    input  logic [31:0] rx_xid,
    input  logic [31:0] rx_yiaddr,
    output logic [31:0] assigned_ip,
    output logic        ip_ok,
    output logic        fail,
    output logic        busy
);

    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam int unsigned AW = $clog2(RETRIES + 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);
    localparam logic [AW-1:0] ATT_MAX  = AW'(RETRIES);

    localparam logic [7:0] MSG_DISCOVER = 8'd1;
    localparam logic [7:0] MSG_OFFER    = 8'd2;
    localparam logic [7:0] MSG_REQUEST  = 8'd3;
    localparam logic [7:0] MSG_ACK      = 8'd5;
    localparam logic [7:0] MSG_NAK      = 8'd6;

    typedef enum logic [2:0] {
        IDLE,
        DISC_TX,
        OFFER_WAIT,
        REQ_TX,
        ACK_WAIT,
        BOUND,
        FAIL
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] attempt_q, attempt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [31:0]   offer_q, offer_d;
    logic [31:0]   assigned_q, assigned_d;
    logic          tx_val_q;
    logic [7:0]    msg_q;
    logic [31:0]   xid_q;
    logic [31:0]   req_ip_q;
    logic [15:0]   ipv4_id_q;
    logic          ip_ok_q, fail_q, busy_q;

    logic          offer_hit, ack_hit, nak_hit, tmo_hit;
    logic [AW-1:0] att_inc;
    logic          enter_disc, enter_req;

    assign offer_hit = rx_val && (rx_msg_type == MSG_OFFER) && (rx_xid == xid_q);
    assign ack_hit   = rx_val && (rx_msg_type == MSG_ACK)   && (rx_xid == xid_q);
    assign nak_hit   = rx_val && (rx_msg_type == MSG_NAK)   && (rx_xid == xid_q);
    assign tmo_hit   = (tmr_q == TMR_LAST);
    assign att_inc   = attempt_q + 1'b1;

    // Qualifying replies are tested before the terminal count so a same-cycle reply wins.
    always_comb begin
        state_d    = state_q;
        attempt_d  = attempt_q;
        tmr_d      = tmr_q;
        offer_d    = offer_q;
        assigned_d = assigned_q;
        case (state_q)
            IDLE, BOUND, FAIL: begin
                if (start) begin
                    state_d   = DISC_TX;
                    attempt_d = '0;
                end
            end
            DISC_TX: begin
                if (tx_done) begin
                    state_d = OFFER_WAIT;
                    tmr_d   = '0;
                end
            end
            OFFER_WAIT: begin
                tmr_d = tmr_q + 1'b1;
                if (offer_hit) begin
                    offer_d = rx_yiaddr;
                    state_d = REQ_TX;
                end else if (tmo_hit) begin
                    attempt_d = att_inc;
                    state_d   = (att_inc == ATT_MAX) ? FAIL : DISC_TX;
                end
            end
            REQ_TX: begin
                if (tx_done) begin
                    state_d = ACK_WAIT;
                    tmr_d   = '0;
                end
            end
            ACK_WAIT: begin
                tmr_d = tmr_q + 1'b1;
                if (ack_hit) begin
                    assigned_d = rx_yiaddr;
                    state_d    = BOUND;
                end else if (nak_hit || tmo_hit) begin
                    attempt_d = att_inc;
                    state_d   = (att_inc == ATT_MAX) ? FAIL : DISC_TX;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign enter_disc = (state_d == DISC_TX) && (state_q != DISC_TX);
    assign enter_req  = (state_d == REQ_TX)  && (state_q != REQ_TX);

    // Transmit fields and status flags are loaded from the next state so they are
    // valid on the first cycle of the new state without any input-to-output path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            attempt_q  <= '0;
            tmr_q      <= '0;
            offer_q    <= '0;
            assigned_q <= '0;
            tx_val_q   <= 1'b0;
            msg_q      <= '0;
            xid_q      <= XID_INIT;
            req_ip_q   <= '0;
            ipv4_id_q  <= '0;
            ip_ok_q    <= 1'b0;
            fail_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            attempt_q  <= attempt_d;
            tmr_q      <= tmr_d;
            offer_q    <= offer_d;
            assigned_q <= assigned_d;
            tx_val_q   <= 1'b0;
            if (enter_disc) begin
                tx_val_q  <= 1'b1;
                msg_q     <= MSG_DISCOVER;
                req_ip_q  <= '0;
                xid_q     <= xid_q + 32'd1;
                ipv4_id_q <= ipv4_id_q + 16'd1;
            end
            if (enter_req) begin
                tx_val_q  <= 1'b1;
                msg_q     <= MSG_REQUEST;
                req_ip_q  <= offer_d;
                ipv4_id_q <= ipv4_id_q + 16'd1;
            end
            ip_ok_q <= (state_d == BOUND);
            fail_q  <= (state_d == FAIL);
            busy_q  <= !(state_d inside {IDLE, BOUND, FAIL});
        end
    end

    assign tx_val      = tx_val_q;
    assign tx_msg_type = msg_q;
    assign tx_xid      = xid_q;
    assign tx_req_ip   = req_ip_q;
    assign tx_src_ip   = '0;
    assign tx_dst_ip   = '1;
    assign tx_ipv4_id  = ipv4_id_q;
    assign assigned_ip = assigned_q;
    assign ip_ok       = ip_ok_q;
    assign fail        = fail_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_dhcp_vlg_core.sv
// Directed/randomized bench for dhcp_vlg_core (TIMEOUT=100, RETRIES=2) checked
// against a transaction-level model of the DHCP client exchange.
module tb_dhcp_vlg_core;

    localparam int unsigned TMO = 100;
    localparam logic [31:0] XID0 = 32'hdeadbeef;
    localparam logic [7:0] T_DISC = 8'd1, T_OFFER = 8'd2, T_REQ = 8'd3, T_ACK = 8'd5, T_NAK = 8'd6;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        tx_val;
    logic [7:0]  tx_msg_type;
    logic [31:0] tx_xid, tx_req_ip, tx_src_ip, tx_dst_ip;
    logic [15:0] tx_ipv4_id;
    logic        tx_done = 1'b0;
    logic        rx_val = 1'b0;
    logic [7:0]  rx_msg_type = '0;
    logic [31:0] rx_xid = '0;
    logic [31:0] rx_yiaddr = '0;
    logic [31:0] assigned_ip;
    logic        ip_ok, fail, busy;

    dhcp_vlg_core #(.TIMEOUT(100), .RETRIES(2), .XID_INIT(32'hdeadbeef)) dut (
        .clk(clk), .rst(rst), .start(start),
        .tx_val(tx_val), .tx_msg_type(tx_msg_type), .tx_xid(tx_xid),
        .tx_req_ip(tx_req_ip), .tx_src_ip(tx_src_ip), .tx_dst_ip(tx_dst_ip),
        .tx_ipv4_id(tx_ipv4_id), .tx_done(tx_done),
        .rx_val(rx_val), .rx_msg_type(rx_msg_type), .rx_xid(rx_xid), .rx_yiaddr(rx_yiaddr),
        .assigned_ip(assigned_ip), .ip_ok(ip_ok), .fail(fail), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  typ;
        logic [31:0] xid;
        logic [31:0] req;
        logic [15:0] id;
    } txrec_t;

    txrec_t txq[$];

    always @(negedge clk)
        if (tx_val === 1'b1)
            txq.push_back(txrec_t'{typ: tx_msg_type, xid: tx_xid, req: tx_req_ip, id: tx_ipv4_id});

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    // Reference model: the header fields the client is expected to use next.
    logic [31:0] m_xid      = XID0;
    logic [15:0] m_id       = '0;
    logic [31:0] m_assigned = '0;
    logic [31:0] yi;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic chk_status(input string tag, input logic ok, input logic fl, input logic bs);
        chk({tag, "_ip_ok"}, 32'(ip_ok), 32'(ok));
        chk({tag, "_fail"}, 32'(fail), 32'(fl));
        chk({tag, "_busy"}, 32'(busy), 32'(bs));
        chk({tag, "_assigned"}, assigned_ip, m_assigned);
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_done();
        repeat ($urandom_range(0, 3)) step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] typ, input logic [31:0] xid, input logic [31:0] addr);
        rx_val = 1'b1; rx_msg_type = typ; rx_xid = xid; rx_yiaddr = addr;
        step();
        rx_val = 1'b0; rx_msg_type = 8'($urandom); rx_xid = $urandom; rx_yiaddr = $urandom;
    endtask

    // Every transmit request carries a fresh IPv4 id; only DISCOVER opens a new transaction.
    task automatic expect_tx(input string tag, input logic [7:0] typ, input logic [31:0] req);
        txrec_t r;
        int unsigned waited;
        waited = 0;
        while (txq.size() == 0 && waited < 20) begin
            step();
            waited++;
        end
        if (typ == T_DISC) m_xid = m_xid + 32'd1;
        m_id = m_id + 16'd1;
        chk({tag, "_seen"}, 32'(txq.size() != 0), 32'd1);
        if (txq.size() != 0) begin
            r = txq.pop_front();
            chk({tag, "_type"}, 32'(r.typ), 32'(typ));
            chk({tag, "_xid"}, r.xid, m_xid);
            chk({tag, "_req_ip"}, r.req, req);
            chk({tag, "_ipv4_id"}, 32'(r.id), 32'(m_id));
        end
        step();
        chk({tag, "_single"}, 32'(txq.size()), 32'd0);
    endtask

    task automatic to_ack_wait(input string tag, input logic [31:0] addr);
        expect_tx({tag, "_disc"}, T_DISC, 32'd0);
        send_done();
        send_rx(T_OFFER, m_xid, addr);
        expect_tx({tag, "_req"}, T_REQ, addr);
        send_done();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values and idle behaviour
        repeat (3) step();
        chk("rst_tx_val", 32'(tx_val), 32'd0);
        chk("rst_msg", 32'(tx_msg_type), 32'd0);
        chk("rst_req_ip", tx_req_ip, 32'd0);
        chk("rst_ipv4_id", 32'(tx_ipv4_id), 32'd0);
        chk("rst_xid", tx_xid, XID0);
        chk("src_ip", tx_src_ip, 32'h0);
        chk("dst_ip", tx_dst_ip, 32'hffffffff);
        chk_status("rst", 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        send_rx(T_OFFER, XID0, $urandom);
        chk("idle_no_tx", 32'(txq.size()), 32'd0);
        chk_status("idle", 1'b0, 1'b0, 1'b0);

        // Happy path
        do_start();
        chk("happy_busy", 32'(busy), 32'd1);
        to_ack_wait("happy", 32'hc0a80132);
        send_rx(T_ACK, m_xid, 32'hc0a80132);
        m_assigned = 32'hc0a80132;
        chk_status("bound", 1'b1, 1'b0, 1'b0);
        chk("bound_ipv4_id", 32'(tx_ipv4_id), 32'd2);

        // Two OFFER_WAIT timeouts with RETRIES=2 end in FAIL
        do_start();
        chk_status("restart", 1'b0, 1'b0, 1'b1);
        expect_tx("tmo_disc", T_DISC, 32'd0);
        send_done();
        repeat (TMO - 1) step();
        chk("tmo1_early", 32'(txq.size()), 32'd0);
        step();
        chk("tmo1_edge", 32'(tx_val), 32'd1);
        expect_tx("tmo1_resend", T_DISC, 32'd0);
        send_done();
        repeat (TMO - 1) step();
        chk("tmo2_early_fail", 32'(fail), 32'd0);
        step();
        chk_status("tmo2", 1'b0, 1'b1, 1'b0);
        repeat (20) step();
        chk("fail_no_tx", 32'(txq.size()), 32'd0);

        // Non-qualifying replies and tx_done in OFFER_WAIT are ignored
        do_start();
        chk("restart_fail_clr", 32'(fail), 32'd0);
        expect_tx("filt_disc", T_DISC, 32'd0);
        send_done();
        for (int k = 0; k < int'(TMO) - 1; k++) begin
            case (k)
                0: begin rx_val = 1'b1; rx_msg_type = T_OFFER; rx_xid = m_xid + 32'd1; rx_yiaddr = $urandom; end
                1: begin rx_val = 1'b1; rx_msg_type = T_ACK; rx_xid = m_xid; rx_yiaddr = $urandom; end
                2: begin rx_val = 1'b1; rx_msg_type = T_NAK; rx_xid = m_xid; rx_yiaddr = $urandom; end
                3: begin rx_val = 1'b1; rx_msg_type = 8'($urandom_range(7, 255)); rx_xid = m_xid; end
                4: tx_done = 1'b1;
                default: ;
            endcase
            step();
            rx_val = 1'b0;
            tx_done = 1'b0;
        end
        chk("filt_early", 32'(txq.size()), 32'd0);
        chk("filt_busy", 32'(busy), 32'd1);
        step();
        expect_tx("filt_tmo", T_DISC, 32'd0);
        send_done();
        yi = $urandom;
        send_rx(T_OFFER, m_xid, yi);
        expect_tx("filt_req", T_REQ, yi);
        send_done();
        send_rx(T_ACK, m_xid, yi);
        m_assigned = yi;
        chk_status("filt_bound", 1'b1, 1'b0, 1'b0);

        // Tie at the terminal count: reply wins and no attempt is consumed
        do_start();
        expect_tx("tie_disc", T_DISC, 32'd0);
        send_done();
        repeat (TMO - 1) step();
        yi = $urandom;
        send_rx(T_OFFER, m_xid, yi);
        expect_tx("tie_req", T_REQ, yi);
        send_done();
        repeat (TMO - 1) step();
        chk("tie_ack_early", 32'(txq.size()), 32'd0);
        step();
        chk("tie_ack_tmo_fail", 32'(fail), 32'd0);
        to_ack_wait("tie_retry", 32'h0a000001);
        send_rx(T_ACK, m_xid, 32'h0a000001);
        m_assigned = 32'h0a000001;
        chk_status("tie_bound", 1'b1, 1'b0, 1'b0);

        // NAK restarts with a new transaction, then ACK binds
        do_start();
        to_ack_wait("nak1", $urandom);
        send_rx(T_NAK, m_xid, $urandom);
        chk_status("nak_retry", 1'b0, 1'b0, 1'b1);
        yi = $urandom;
        to_ack_wait("nak2", yi);
        send_rx(T_ACK, m_xid, yi);
        m_assigned = yi;
        chk_status("nak_bound", 1'b1, 1'b0, 1'b0);

        // Second NAK reaches RETRIES and fails
        do_start();
        to_ack_wait("nakf1", $urandom);
        send_rx(T_NAK, m_xid, $urandom);
        to_ack_wait("nakf2", $urandom);
        send_rx(T_NAK, m_xid, $urandom);
        chk_status("nak_fail", 1'b0, 1'b1, 1'b0);
        chk("nak_fail_no_tx", 32'(txq.size()), 32'd0);

        // Asynchronous reset in ACK_WAIT
        do_start();
        to_ack_wait("rstw", $urandom);
        repeat ($urandom_range(1, 10)) step();
        rst = 1'b0;
        #1;
        m_xid = XID0;
        m_id = '0;
        m_assigned = '0;
        chk("arst_tx_val", 32'(tx_val), 32'd0);
        chk("arst_msg", 32'(tx_msg_type), 32'd0);
        chk("arst_req_ip", tx_req_ip, 32'd0);
        chk("arst_ipv4_id", 32'(tx_ipv4_id), 32'd0);
        chk("arst_xid", tx_xid, XID0);
        chk_status("arst", 1'b0, 1'b0, 1'b0);
        repeat (2) step();
        rst = 1'b1;
        repeat (2) step();
        chk("release_no_tx", 32'(txq.size()), 32'd0);
        chk("release_busy", 32'(busy), 32'd0);
        do_start();
        expect_tx("post_rst_disc", T_DISC, 32'd0);
        chk("post_rst_xid", tx_xid, 32'hdeadbef0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
